// File: rtl/sram_mem_arbiter_pkg.sv
// Shared definitions for the SRAM arbiter: FSM state encodings, owner
// constants and the default memory read latency.
package sram_mem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2,
        ARB_RESP  = 2'd3
    } arb_state_e;

    localparam logic GRANT_INST = 1'b0;
    localparam logic GRANT_DATA = 1'b1;

    localparam int MEM_LAT_DEFAULT = 1;

endpackage

// File: rtl/sram_mem_arbiter_rr2.sv
// Two-request round-robin picker: on contention the requester that did not
// win last time gets the grant.
module rr2_arbiter
    import sram_mem_arbiter_pkg::*;
(
    input  logic req_inst,
    input  logic req_data,
    input  logic last_grant,
    output logic grant_valid,
    output logic grant_owner
);

    always_comb begin
        grant_valid = req_inst | req_data;
        grant_owner = GRANT_INST;
        if (req_inst && req_data) begin
            grant_owner = ~last_grant;
        end else if (req_data) begin
            grant_owner = GRANT_DATA;
        end
    end

endmodule

// File: rtl/sram_mem_arbiter.sv
// Shares one single-port SRAM between instruction fetch and data access,
// one transaction at a time, with registered bus outputs.
//
// Handshake: a requester holds req high until its ok pulse (data may also
// abandon via data_cancel); ok is a single-cycle pulse in the RESP state and
// the requester must ignore it if it dropped req meanwhile.
module sram_mem_arbiter
    import sram_mem_arbiter_pkg::*;
#(
    parameter int MEM_LAT = MEM_LAT_DEFAULT,
    parameter int AW      = 32
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          inst_req,
    input  logic [AW-1:0] inst_addr,
    output logic [31:0]   inst_rdata,
    output logic          inst_ok,
    input  logic          data_req,
    input  logic [3:0]    data_wen,
    input  logic [AW-1:0] data_addr,
    input  logic [31:0]   data_wdata,
    output logic [31:0]   data_rdata,
    output logic          data_ok,
    input  logic          data_cancel,
    output logic          mem_en,
    output logic [3:0]    mem_wen,
    output logic [AW-1:0] mem_addr,
    output logic [31:0]   mem_wdata,
    input  logic [31:0]   mem_rdata,
    output logic          busy,
    output arb_state_e    dbg_state
);

    localparam logic [2:0] LAT = 3'(MEM_LAT);

    arb_state_e state, state_n;
    logic       owner;
    logic       last_grant;
    logic       cancelled;
    logic [2:0] cnt;
    logic       grant_valid;
    logic       grant_owner;
    logic       data_eligible;
    logic       kill_now;

    assign data_eligible = data_req & ~data_cancel;
    // A cancel arriving in the capture cycle must still suppress the pulse.
    assign kill_now      = cancelled | data_cancel;
    assign dbg_state     = state;

    rr2_arbiter u_rr2 (
        .req_inst   (inst_req),
        .req_data   (data_eligible),
        .last_grant (last_grant),
        .grant_valid(grant_valid),
        .grant_owner(grant_owner)
    );

    always_comb begin
        state_n = state;
        case (state)
            ARB_IDLE:  if (grant_valid) state_n = ARB_ISSUE;
            ARB_ISSUE: state_n = ARB_WAIT;
            ARB_WAIT:  if (cnt == LAT) state_n = ARB_RESP;
            ARB_RESP:  state_n = ARB_IDLE;
            default:   state_n = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state      <= ARB_IDLE;
            owner      <= GRANT_INST;
            last_grant <= GRANT_INST;
            cancelled  <= 1'b0;
            cnt        <= 3'd0;
            mem_en     <= 1'b0;
            mem_wen    <= 4'b0000;
            mem_addr   <= '0;
            mem_wdata  <= 32'd0;
            inst_ok    <= 1'b0;
            data_ok    <= 1'b0;
            inst_rdata <= 32'd0;
            data_rdata <= 32'd0;
            busy       <= 1'b0;
        end else begin
            state   <= state_n;
            busy    <= (state_n != ARB_IDLE);
            mem_en  <= 1'b0;
            inst_ok <= 1'b0;
            data_ok <= 1'b0;
            case (state)
                ARB_IDLE: begin
                    if (grant_valid) begin
                        owner      <= grant_owner;
                        last_grant <= grant_owner;
                        cancelled  <= 1'b0;
                        mem_en     <= 1'b1;
                        if (grant_owner == GRANT_DATA) begin
                            mem_wen   <= data_wen;
                            mem_addr  <= data_addr;
                            mem_wdata <= data_wdata;
                        end else begin
                            mem_wen   <= 4'b0000;
                            mem_addr  <= inst_addr;
                            mem_wdata <= 32'd0;
                        end
                    end
                end
                ARB_ISSUE: begin
                    cnt     <= 3'd1;
                    mem_wen <= 4'b0000;
                    if (owner == GRANT_DATA && data_cancel) cancelled <= 1'b1;
                end
                ARB_WAIT: begin
                    if (owner == GRANT_DATA && data_cancel) cancelled <= 1'b1;
                    if (cnt == LAT) begin
                        if (owner == GRANT_INST) begin
                            inst_ok    <= 1'b1;
                            inst_rdata <= mem_rdata;
                        end else if (!kill_now) begin
                            data_ok    <= 1'b1;
                            data_rdata <= mem_rdata;
                        end
                    end else begin
                        cnt <= cnt + 3'd1;
                    end
                end
                ARB_RESP: begin
                    cancelled <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_mem_arbiter.sv
// Directed bench for sram_mem_arbiter: a MEM_LAT=1 instance and a MEM_LAT=3
// instance, each driven against a small behavioural memory.
module tb_sram_mem_arbiter;
  import sram_mem_arbiter_pkg::*;

  logic clk;
  logic resetn;

  // MEM_LAT=1 instance signals
  logic        inst_req, inst_ok, data_req, data_ok, data_cancel, mem_en, busy;
  logic [31:0] inst_addr, inst_rdata, data_addr, data_wdata, data_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  data_wen, mem_wen;
  arb_state_e  dbg_state;

  // MEM_LAT=3 instance signals
  logic        l3_inst_req, l3_inst_ok, l3_data_req, l3_data_ok, l3_data_cancel, l3_mem_en, l3_busy;
  logic [31:0] l3_inst_addr, l3_inst_rdata, l3_data_addr, l3_data_wdata, l3_data_rdata;
  logic [31:0] l3_mem_addr, l3_mem_wdata, l3_mem_rdata, l3_s1, l3_s2;
  logic [3:0]  l3_data_wen, l3_mem_wen;
  arb_state_e  l3_dbg_state;

  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_mem_arbiter #(.MEM_LAT(1), .AW(32)) u_dut (
    .clk(clk), .resetn(resetn),
    .inst_req(inst_req), .inst_addr(inst_addr), .inst_rdata(inst_rdata), .inst_ok(inst_ok),
    .data_req(data_req), .data_wen(data_wen), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_rdata(data_rdata), .data_ok(data_ok), .data_cancel(data_cancel),
    .mem_en(mem_en), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .dbg_state(dbg_state)
  );

  sram_mem_arbiter #(.MEM_LAT(3), .AW(32)) u_dut3 (
    .clk(clk), .resetn(resetn),
    .inst_req(l3_inst_req), .inst_addr(l3_inst_addr), .inst_rdata(l3_inst_rdata), .inst_ok(l3_inst_ok),
    .data_req(l3_data_req), .data_wen(l3_data_wen), .data_addr(l3_data_addr), .data_wdata(l3_data_wdata),
    .data_rdata(l3_data_rdata), .data_ok(l3_data_ok), .data_cancel(l3_data_cancel),
    .mem_en(l3_mem_en), .mem_wen(l3_mem_wen), .mem_addr(l3_mem_addr), .mem_wdata(l3_mem_wdata),
    .mem_rdata(l3_mem_rdata), .busy(l3_busy), .dbg_state(l3_dbg_state)
  );

  // ---------------- memory models ----------------
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'hBFC0_0000: mem_word = 32'h3C1A_0001;
      32'h8000_1004: mem_word = 32'hA5A5_5A5A;
      32'h8000_2000: mem_word = 32'h1234_5678;
      default:       mem_word = a ^ 32'h5555_5555;
    endcase
  endfunction

  // Read data is valid for exactly one cycle, MEM_LAT cycles after mem_en.
  always @(posedge clk) begin
    mem_rdata <= (mem_en && mem_wen == 4'b0000) ? mem_word(mem_addr) : 32'hBAD0_BAD0;
    l3_s1 <= (l3_mem_en && l3_mem_wen == 4'b0000) ? mem_word(l3_mem_addr) : 32'hBAD1_BAD1;
    l3_s2 <= l3_s1;
    l3_mem_rdata <= l3_s2;
  end

  // ---------------- driver / check tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_state"}, 64'(dbg_state), 64'(ARB_IDLE));
    chk({tag, "_mem_en"}, 64'(mem_en), 64'd0);
    chk({tag, "_mem_wen"}, 64'(mem_wen), 64'd0);
    chk({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    chk({tag, "_inst_ok"}, 64'(inst_ok), 64'd0);
    chk({tag, "_data_ok"}, 64'(data_ok), 64'd0);
    chk({tag, "_inst_rdata"}, 64'(inst_rdata), 64'd0);
    chk({tag, "_data_rdata"}, 64'(data_rdata), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_addr = 0; data_req = 0; data_wen = 0; data_addr = 0; data_wdata = 0; data_cancel = 0;
    l3_inst_req = 0; l3_inst_addr = 0; l3_data_req = 0; l3_data_wen = 0; l3_data_addr = 0;
    l3_data_wdata = 0; l3_data_cancel = 0;
    step(); step();
    chk_idle("reset");
    chk("reset_l3_busy", 64'(l3_busy), 64'd0);

    // Single instruction fetch
    resetn = 1'b1;
    inst_req = 1; inst_addr = 32'hBFC0_0000;
    step();
    chk("if_mem_en", 64'(mem_en), 64'd1);
    chk("if_mem_addr", 64'(mem_addr), 64'hBFC0_0000);
    chk("if_mem_wen", 64'(mem_wen), 64'd0);
    chk("if_busy", 64'(busy), 64'd1);
    step();
    chk("if_wait_mem_en", 64'(mem_en), 64'd0);
    chk("if_wait_ok", 64'(inst_ok), 64'd0);
    step();
    chk("if_inst_ok", 64'(inst_ok), 64'd1);
    chk("if_inst_rdata", 64'(inst_rdata), 64'h3C1A_0001);
    chk("if_data_ok", 64'(data_ok), 64'd0);
    inst_req = 0;
    step();
    chk("if_busy_end", 64'(busy), 64'd0);
    chk("if_ok_end", 64'(inst_ok), 64'd0);

    // Both requesters from reset: grants alternate D,I,D,I
    resetn = 1'b0;
    inst_req = 1; data_req = 1; data_addr = 32'h8000_1004; data_wen = 4'b0000;
    step();
    resetn = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
      chk("rr_mem_en", 64'(mem_en), 64'd1);
      chk("rr_mem_addr", 64'(mem_addr), (k % 2 == 0) ? 64'h8000_1004 : 64'hBFC0_0000);
      step(); step();
      chk("rr_data_ok", 64'(data_ok), (k % 2 == 0) ? 64'd1 : 64'd0);
      chk("rr_inst_ok", 64'(inst_ok), (k % 2 == 0) ? 64'd0 : 64'd1);
      if (k % 2 == 0) chk("rr_data_rdata", 64'(data_rdata), 64'hA5A5_5A5A);
      else            chk("rr_inst_rdata", 64'(inst_rdata), 64'h3C1A_0001);
      if (k == 3) begin
        inst_req = 0; data_req = 0;
      end
      step();
    end

    // Partial-word store
    data_req = 1; data_wen = 4'b1100; data_addr = 32'h8000_0002; data_wdata = 32'hBEEF_BEEF;
    step();
    chk("st_mem_en", 64'(mem_en), 64'd1);
    chk("st_mem_wen", 64'(mem_wen), 64'hC);
    chk("st_mem_addr", 64'(mem_addr), 64'h8000_0002);
    chk("st_mem_wdata", 64'(mem_wdata), 64'hBEEF_BEEF);
    step();
    chk("st_wait_mem_en", 64'(mem_en), 64'd0);
    chk("st_wait_mem_wen", 64'(mem_wen), 64'd0);
    step();
    chk("st_data_ok", 64'(data_ok), 64'd1);
    chk("st_inst_ok", 64'(inst_ok), 64'd0);
    data_req = 0; data_wen = 4'b0000;
    step();
    chk("st_busy_end", 64'(busy), 64'd0);

    // Cancel during WAIT of a data read, then an inst fetch
    data_req = 1; data_addr = 32'h8000_1004;
    step();
    step();
    data_cancel = 1; data_req = 0;
    step();
    chk("cw_state", 64'(dbg_state), 64'(ARB_RESP));
    chk("cw_data_ok", 64'(data_ok), 64'd0);
    data_cancel = 0; inst_req = 1; inst_addr = 32'hBFC0_0000;
    step();
    step();
    chk("cw_if_mem_en", 64'(mem_en), 64'd1);
    chk("cw_if_mem_addr", 64'(mem_addr), 64'hBFC0_0000);
    step(); step();
    chk("cw_inst_ok", 64'(inst_ok), 64'd1);
    chk("cw_inst_rdata", 64'(inst_rdata), 64'h3C1A_0001);
    chk("cw_data_ok2", 64'(data_ok), 64'd0);
    inst_req = 0;
    step();

    // Cancel during ISSUE of a data read
    data_req = 1;
    step();
    data_cancel = 1; data_req = 0;
    step();
    data_cancel = 0;
    step();
    chk("ci_state", 64'(dbg_state), 64'(ARB_RESP));
    chk("ci_data_ok", 64'(data_ok), 64'd0);
    step();
    chk("ci_busy_end", 64'(busy), 64'd0);

    // Cancel together with request in IDLE: no grant
    data_req = 1; data_cancel = 1;
    step();
    chk("cidle_mem_en", 64'(mem_en), 64'd0);
    chk("cidle_busy", 64'(busy), 64'd0);
    chk("cidle_state", 64'(dbg_state), 64'(ARB_IDLE));
    data_req = 0; data_cancel = 0;
    step();

    // Reset during WAIT of an inst fetch
    inst_req = 1;
    step();
    step();
    chk("rw_state_wait", 64'(dbg_state), 64'(ARB_WAIT));
    resetn = 1'b0;
    step();
    chk_idle("rst_wait");
    resetn = 1'b1; inst_req = 0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rw_no_ok", 64'(inst_ok), 64'd0);
    end

    // MEM_LAT=3 data read
    l3_data_req = 1; l3_data_addr = 32'h8000_2000;
    step();
    chk("l3_mem_en", 64'(l3_mem_en), 64'd1);
    chk("l3_mem_addr", 64'(l3_mem_addr), 64'h8000_2000);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("l3_wait_mem_en", 64'(l3_mem_en), 64'd0);
      chk("l3_wait_ok", 64'(l3_data_ok), 64'd0);
      chk("l3_wait_busy", 64'(l3_busy), 64'd1);
    end
    step();
    chk("l3_data_ok", 64'(l3_data_ok), 64'd1);
    chk("l3_data_rdata", 64'(l3_data_rdata), 64'h1234_5678);
    l3_data_req = 0;
    step();
    chk("l3_busy_end", 64'(l3_busy), 64'd0);
    chk("l3_ok_end", 64'(l3_data_ok), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
